// File: rtl/sample_pipe_if.sv
// sample_pipe_if: producer/consumer bundle for sample_pipe.
//   master : drives a, a_vld, ch_en, flush; observes x, x_vld, occ (and out_cnt)
//   slave  : the delay line itself
// Optional macro SAMPLE_PIPE_CNT_EN adds the 16-bit out_cnt signal.
interface sample_pipe_if #(
    parameter int unsigned CH    = 2,
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 3
);
    localparam int unsigned DW    = CH * W;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DW-1:0]    a;
    logic             a_vld;
    logic [CH-1:0]    ch_en;
    logic             flush;
    logic [DW-1:0]    x;
    logic             x_vld;
    logic [OCC_W-1:0] occ;
`ifdef SAMPLE_PIPE_CNT_EN
    logic [15:0]      out_cnt;

    modport master (output a, a_vld, ch_en, flush, input x, x_vld, occ, out_cnt);
    modport slave  (input a, a_vld, ch_en, flush, output x, x_vld, occ, out_cnt);
`else
    modport master (output a, a_vld, ch_en, flush, input x, x_vld, occ);
    modport slave  (input a, a_vld, ch_en, flush, output x, x_vld, occ);
`endif
endinterface

// File: rtl/sample_pipe.sv
// sample_pipe: fixed-latency, channel-aligned multi-channel sampling delay line.
// A sample accepted on a_vld appears on x/x_vld exactly DEPTH cycles later.
// Disabled channels load TIE instead of input data. flush invalidates all stages.
// Ports:
//   clk    : sole clock, posedge
//   rst_n  : asynchronous active-low reset
//   bus    : sample_pipe_if.slave (a, a_vld, ch_en, flush in; x, x_vld, occ out)
// Optional macro SAMPLE_PIPE_CNT_EN: adds bus.out_cnt, a saturating count of
// cycles with x_vld=1, cleared only by rst_n.
module sample_pipe #(
    parameter int unsigned    CH    = 2,
    parameter int unsigned    W     = 8,
    parameter int unsigned    DEPTH = 3,
    parameter logic [W-1:0]   TIE   = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    sample_pipe_if.slave bus
);
    localparam int unsigned DW    = CH * W;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [OCC_W-1:0] r_occ;
    logic [DW-1:0]    w_d0;
    logic             w_acc;
    logic             w_out;

    // Stage-0 load value: per-channel tie-off substitution
    always_comb begin
        w_d0 = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            w_d0[c*W +: W] = bus.ch_en[c] ? bus.a[c*W +: W] : TIE;
        end
    end

    assign w_acc = bus.a_vld & ~bus.flush;
    assign w_out = r_vld[DEPTH-1];

    // Data shift: stage 0 holds when idle, later stages free-run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned d = 0; d < DEPTH; d++) begin
                r_data[d] <= '0;
            end
        end else begin
            if (bus.a_vld) begin
                r_data[0] <= w_d0;
            end
            for (int unsigned d = 1; d < DEPTH; d++) begin
                r_data[d] <= r_data[d-1];
            end
        end
    end

    // Valid shift; flush clears every stage but leaves data untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (bus.flush) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= bus.a_vld;
            for (int unsigned d = 1; d < DEPTH; d++) begin
                r_vld[d] <= r_vld[d-1];
            end
        end
    end

    // Occupancy counter tracking the population of r_vld
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (bus.flush) begin
            r_occ <= '0;
        end else begin
            case ({w_acc, w_out})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign bus.x     = r_data[DEPTH-1];
    assign bus.x_vld = r_vld[DEPTH-1];
    assign bus.occ   = r_occ;

`ifdef SAMPLE_PIPE_CNT_EN
    logic [15:0] r_out_cnt;

    // Saturating count of valid output cycles; flush does not clear it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_cnt <= '0;
        end else if (w_out && (r_out_cnt != 16'hFFFF)) begin
            r_out_cnt <= r_out_cnt + 16'd1;
        end
    end

    assign bus.out_cnt = r_out_cnt;
`endif
endmodule

// File: doc/sample_pipe.md
# sample_pipe

Parametrised multi-channel sampling delay line: the next generation of the single-flop capture cells. Captures CH channels of W-bit data on a qualifying valid and delivers them exactly DEPTH cycles later with an aligned valid. Per-channel enables substitute a constant tie-off value for unused channels, so an unused input never propagates. Sits between asynchronous-ish producers and downstream compare/ECO logic that needs fixed-latency, channel-aligned samples.

## Interface
- CH, 2, number of channels (>=1)
- W, 8, data width per channel (>=1)
- DEPTH, 3, pipeline stages = latency in cycles (>=1)
- TIE, 0, W-bit value loaded for a disabled channel
- clk  in  1  sole clock, all state rises on posedge
- rst_n  in  1  asynchronous active-low reset
- a  in  CH*W  input samples, channel c at a[c*W +: W]
- a_vld  in  1  a is valid this cycle
- ch_en  in  CH  per-channel enable, sampled with a_vld
- flush  in  1  synchronous pipeline invalidate
- x  out  CH*W  delayed samples, same packing as a
- x_vld  out  1  x is valid
- occ  out  $clog2(DEPTH+1)  number of valid entries held in the pipe

## Operation
- Reset (rst_n=0, asynchronous): all stage data = 0, all stage valid bits = 0; x=0, x_vld=0, occ=0 (and out_cnt=0 if configured). Release is synchronised by the caller; block needs no extra cycle after release.
- Stage 0, each cycle: valid0 <= a_vld & ~flush. If a_vld=1, data0 channel c <= ch_en[c] ? a[c] : TIE. If a_vld=0, data0 holds.
- Stage k (1..DEPTH-1), each cycle: valid_k <= valid_{k-1} & ~flush; data_k <= data_{k-1} (free-running shift, no stall).
- x = data_{DEPTH-1}, x_vld = valid_{DEPTH-1}; both are registered outputs.
- flush: next cycle every valid bit is 0; data registers unchanged. flush with a_vld in same cycle: flush wins, that sample is dropped (data0 still loads, valid0=0).
- occ = population count of valid bits, registered-consistent with them (never exceeds DEPTH). Held as a counter: +1 on accepted input, -1 on valid leaving last stage, both = no change, flush -> 0.
- ch_en changes take effect only on samples accepted in that cycle; samples already in flight are unaffected.
- DEPTH=1: single register stage, occ is 1 bit.

## Timing
- Latency: sample accepted at edge n appears on x/x_vld after edge n+DEPTH-1, i.e. DEPTH cycles from a_vld assertion to x_vld, one sample per cycle throughput.
- Back-to-back a_vld for L cycles -> x_vld high for exactly L consecutive cycles, DEPTH cycles later.
- flush at edge n: x_vld=0 and occ=0 after edge n; a_vld at edge n+1 is accepted normally.
- rst_n asserted mid-stream: outputs drop to reset values immediately, independent of clk.

## Configuration
- SAMPLE_PIPE_CNT_EN defined: adds output out_cnt (out, 16) counting cycles with x_vld=1; saturates at 16'hFFFF; cleared only by rst_n, not by flush.
- Not defined: out_cnt port and its register are absent; all other behaviour identical.

## Test plan
- Reset: rst_n=0 with random a/a_vld -> x=0, x_vld=0, occ=0; after release, first a_vld=1 a=16'hA55A ch_en=2'b11 -> x=16'hA55A, x_vld=1 exactly 3 cycles later.
- Tie-off: a=16'h1234, ch_en=2'b01, TIE=0 -> x=16'h0034; ch_en=2'b10 -> x=16'h1200.
- Streaming: a_vld high 5 cycles with a=1..5 -> x_vld high 5 cycles, x=1..5 in order, occ rises 1,2,3 and holds 3 then falls 2,1,0.
- Flush collision: pipe full (occ=3), flush=1 with a_vld=1 a=16'hFFFF -> next cycle occ=0, x_vld=0, 16'hFFFF never appears with x_vld=1.
- Async reset mid-stream: rst_n pulled low between edges with occ=2 -> x_vld, occ, x zero immediately, before next posedge.
- SAMPLE_PIPE_CNT_EN: 70000 cycles of continuous a_vld -> out_cnt=16'hFFFF and stays; flush does not clear it; rst_n clears to 0.
